mdom_scdb_hdr_arbiter: RTL and testbench
========================================

Name: mdom_scdb_hdr_arbiter

Overview:
- Round-robin scheduler sharing the single scdb header/waveform readout path between N_CHAN per-channel header FIFOs.
- Selects one channel with a pending 111-bit header bundle, pops it, and presents it downstream on a valid/ready handshake.
- Holds off the next grant until the downstream waveform readout signals completion.
- Keeps split waveforms contiguous: a header with partial_wfm=1 locks the arbiter onto its channel.

Parameters:
- N_CHAN, 24: number of requesting channels (1..32).
- BUNDLE_W, 111: header bundle width. Field map: evt_ltc [48:0], start_addr [59:49], stop_addr [70:60], trig_src [72:71], cnst_run [73], pre_conf [78:74], sync_rdy [79], bsum [98:80], bsum_len_sel [101:99], bsum_valid [102], local_coinc [103], partial_wfm [104], continued_wfm [105], channel_idx [110:106].

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable.
- hdr_rdy  in  N_CHAN  per-channel FIFO non-empty. FIFOs are first-word-fall-through.
- hdr_bundles  in  N_CHAN*BUNDLE_W  FIFO head words; channel i occupies [i*BUNDLE_W +: BUNDLE_W].
- hdr_rd  out  N_CHAN  one-hot, one-cycle FIFO pop strobe.
- out_bundle  out  BUNDLE_W  registered granted header.
- out_valid  out  1  header available.
- out_ready  in  1  downstream accepts the header.
- out_chan  out  5  granted channel index.
- wfm_done  in  1  single-cycle pulse: waveform readout for the accepted header is finished.
- busy  out  1  high in any state other than IDLE.
- locked  out  1  partial-waveform lock active.
- err_chan_mismatch  out  1  sticky error flag.
- err_clr  in  1  clears err_chan_mismatch.
- hdr_cnt  out  32  number of headers accepted downstream; wraps.

Behaviour:
- Reset values: hdr_rd=0, out_bundle=0, out_valid=0, out_chan=0, busy=0, locked=0, err_chan_mismatch=0, hdr_cnt=0, rr pointer=0, state=IDLE. Reset takes effect immediately in any state and abandons any transaction in flight.
- FSM states: IDLE, PRESENT, WAIT_WFM.
- IDLE, no grant when:
  - en=0; in this case locked is also cleared, or
  - locked=1 and hdr_rdy[lock_chan]=0, or
  - no bit of hdr_rdy is set.
- IDLE, grant selection:
  - locked=1: grant = lock_chan.
  - Otherwise: grant = the first set hdr_rdy bit at or above the rr pointer, searching circularly and wrapping from N_CHAN-1 to 0.
- IDLE, on grant g (same cycle):
  - hdr_rd[g]=1 for exactly one cycle.
  - out_bundle <= hdr_bundles slice g; out_chan <= g.
  - If bundle[110:106] != g, set err_chan_mismatch. The header is still forwarded unmodified.
  - Next state PRESENT.
  - Latency: hdr_rdy rising edge to out_valid high is 1 clock.
- PRESENT:
  - out_valid=1; out_bundle and out_chan are held stable.
  - On out_valid & out_ready: out_valid deasserts the next cycle, hdr_cnt increments, next state WAIT_WFM.
- WAIT_WFM:
  - On wfm_done=1, return to IDLE.
  - If the held bundle has partial_wfm [104]=1: locked<=1, lock_chan<=out_chan, rr pointer unchanged.
  - Else: locked<=0, rr pointer <= (out_chan+1) mod N_CHAN.
  - wfm_done in any other state is ignored.
- Minimum spacing between grants is 3 cycles: grant, accept, done, then IDLE.
- en deasserted mid-transaction: the current transaction completes normally; no new grant is issued after it.
- err_clr and a mismatch in the same cycle: the set wins.
- hdr_cnt wraps from 0xFFFFFFFF to 0.
- hdr_rd is never asserted for a channel whose hdr_rdy=0.
- At most one hdr_rd bit is set in any cycle.

Test Plan:
- Fairness: hdr_rdy=all ones with every FIFO holding 2 headers, out_ready=1, wfm_done 2 cycles after accept → grant order 0,1,…,23,0,1,…,23; hdr_cnt=48.
- Skip/wrap: rr pointer at 22 after channel 21 is served; hdr_rdy has only bits 3 and 22 set → grant 22, then 3; pointer ends at 4.
- Partial lock: ch5 header with partial_wfm=1, ch6 also pending → locked=1 after wfm_done. Next grant is ch5 even while ch6 is pending, and ch5 empty for 10 cycles produces no grant. A ch5 header with partial_wfm=0 clears the lock; the next grant is ch6.
- Backpressure: out_ready=0 for 20 cycles → out_valid stays high, out_bundle stable, hdr_rd all 0, hdr_cnt unchanged until out_ready=1.
- Mismatch: ch7 bundle with channel_idx=9 → err_chan_mismatch=1 and the header is forwarded unchanged. err_clr in the same cycle as a new mismatch leaves the flag at 1; err_clr alone clears it.
- Reset mid-op: assert rst in WAIT_WFM with locked=1 → all outputs at reset values immediately. After release, the first grant is the lowest set hdr_rdy bit.

Source files
------------

// File: rtl/mdom_scdb_hdr_arbiter_if.sv
// Header readout bus: per-channel FIFO heads/pops on one side, the granted
// header with its valid/ready handshake and waveform-done pulse on the other.
interface mdom_scdb_hdr_arbiter_if #(
    parameter int unsigned N_CHAN   = 24,
    parameter int unsigned BUNDLE_W = 111
);
    logic [N_CHAN-1:0]          hdr_rdy;
    logic [N_CHAN*BUNDLE_W-1:0] hdr_bundles;
    logic [N_CHAN-1:0]          hdr_rd;
    logic [BUNDLE_W-1:0]        out_bundle;
    logic                       out_valid;
    logic                       out_ready;
    logic [4:0]                 out_chan;
    logic                       wfm_done;

    // Arbiter side
    modport master (
        input  hdr_rdy, hdr_bundles, out_ready, wfm_done,
        output hdr_rd, out_bundle, out_valid, out_chan
    );

    // FIFO bank / downstream readout side
    modport slave (
        output hdr_rdy, hdr_bundles, out_ready, wfm_done,
        input  hdr_rd, out_bundle, out_valid, out_chan
    );
endinterface

// File: rtl/mdom_scdb_hdr_arbiter.sv
// Round-robin header arbiter: grants one channel's FIFO head at a time onto the
// shared header/waveform readout path, and keeps split waveforms contiguous by
// locking onto a channel whose header has partial_wfm set.
module mdom_scdb_hdr_arbiter #(
    parameter int unsigned N_CHAN   = 24,
    parameter int unsigned BUNDLE_W = 111
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    mdom_scdb_hdr_arbiter_if.master bus,
    output logic                    busy,
    output logic                    locked,
    output logic                    err_chan_mismatch,
    input  logic                    err_clr,
    output logic [31:0]             hdr_cnt
);

    localparam int unsigned ChanLsb    = 106;
    localparam int unsigned PartialBit = 104;

    typedef enum logic [1:0] {StIdle, StPresent, StWaitWfm} state_e;

    state_e              state_q, state_d;
    logic [4:0]          rr_ptr_q;
    logic [4:0]          lock_chan_q;
    logic                locked_q;
    logic [BUNDLE_W-1:0] out_bundle_q;
    logic [4:0]          out_chan_q;
    logic                err_q;
    logic [31:0]         hdr_cnt_q;

    logic                grant_vld;
    logic [4:0]          grant_idx;
    logic [BUNDLE_W-1:0] grant_bundle;
    logic                accept;
    int unsigned         cand;

    assign accept = (state_q == StPresent) && bus.out_ready;

    // Grant search: locked channel only, else first ready at/after the rr pointer.
    // Gated by rst so no pop strobe escapes while reset is held.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (state_q == StIdle && en && !rst) begin
            if (locked_q) begin
                if (bus.hdr_rdy[lock_chan_q]) begin
                    grant_vld = 1'b1;
                    grant_idx = lock_chan_q;
                end
            end else begin
                for (int unsigned i = 0; i < N_CHAN; i++) begin
                    cand = 32'(rr_ptr_q) + i;
                    if (cand >= N_CHAN) begin
                        cand = cand - N_CHAN;
                    end
                    if (!grant_vld && bus.hdr_rdy[cand[4:0]]) begin
                        grant_vld = 1'b1;
                        grant_idx = cand[4:0];
                    end
                end
            end
        end
        grant_bundle = bus.hdr_bundles[32'(grant_idx) * BUNDLE_W +: BUNDLE_W];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (grant_vld)    state_d = StPresent;
            StPresent: if (bus.out_ready) state_d = StWaitWfm;
            StWaitWfm: if (bus.wfm_done)  state_d = StIdle;
            default:                      state_d = StIdle;
        endcase
    end

    // Outputs: pop strobe is combinational in the grant cycle, the rest registered
    always_comb begin
        bus.hdr_rd = '0;
        if (grant_vld) begin
            bus.hdr_rd[grant_idx] = 1'b1;
        end
        bus.out_valid     = (state_q == StPresent);
        bus.out_bundle    = out_bundle_q;
        bus.out_chan      = out_chan_q;
        busy              = (state_q != StIdle);
        locked            = locked_q;
        err_chan_mismatch = err_q;
        hdr_cnt           = hdr_cnt_q;
    end

    // Datapath: captured header, rr pointer / lock, error flag, accept counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_bundle_q <= '0;
            out_chan_q   <= '0;
            rr_ptr_q     <= '0;
            lock_chan_q  <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            hdr_cnt_q    <= '0;
        end else begin
            if (grant_vld) begin
                out_bundle_q <= grant_bundle;
                out_chan_q   <= grant_idx;
            end
            // A new mismatch takes priority over a simultaneous clear
            if (grant_vld && (grant_bundle[ChanLsb +: 5] != grant_idx)) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (accept) begin
                hdr_cnt_q <= hdr_cnt_q + 32'd1;
            end
            if (state_q == StIdle && !en) begin
                locked_q <= 1'b0;
            end
            if (state_q == StWaitWfm && bus.wfm_done) begin
                if (out_bundle_q[PartialBit]) begin
                    locked_q    <= 1'b1;
                    lock_chan_q <= out_chan_q;
                end else begin
                    locked_q <= 1'b0;
                    rr_ptr_q <= (32'(out_chan_q) == N_CHAN - 1) ? 5'd0 : out_chan_q + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdom_scdb_hdr_arbiter.sv
// Bench for mdom_scdb_hdr_arbiter: FWFT FIFO model per channel, scoreboard of
// expected (channel, header) pairs checked at every downstream accept.
module tb_mdom_scdb_hdr_arbiter;

    localparam int N = 24;
    localparam int W = 111;

    typedef struct packed {
        logic [4:0]   chan;
        logic [W-1:0] bundle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        err_clr;
    logic        busy;
    logic        locked;
    logic        err;
    logic [31:0] hdr_cnt;

    mdom_scdb_hdr_arbiter_if #(.N_CHAN(N), .BUNDLE_W(W)) bus ();

    mdom_scdb_hdr_arbiter #(.N_CHAN(N), .BUNDLE_W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .bus               (bus),
        .busy              (busy),
        .locked            (locked),
        .err_chan_mismatch (err),
        .err_clr           (err_clr),
        .hdr_cnt           (hdr_cnt)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fmem [N][4];
    int           fcnt [N];
    exp_t         sb [$];
    int           checks = 0;
    int           failures = 0;
    int           wfm_timer = 0;
    int           wfm_delay = 2;
    bit           auto_wfm = 1'b1;

    for (genvar g = 0; g < N; g++) begin : g_fifo
        assign bus.hdr_rdy[g]             = (fcnt[g] != 0);
        assign bus.hdr_bundles[g*W +: W]  = fmem[g][0];
    end

    function automatic logic [W-1:0] mk(int idx, bit partial);
        logic [127:0] r;
        logic [W-1:0] b;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = r[W-1:0];
        b[110:106] = idx[4:0];
        b[104] = partial;
        return b;
    endfunction

    task automatic push_hdr(int chan, logic [W-1:0] b, bit expect_it);
        exp_t e;
        fmem[chan][fcnt[chan]] = b;
        fcnt[chan]++;
        if (expect_it) begin
            e.chan = chan[4:0];
            e.bundle = b;
            sb.push_back(e);
        end
    endtask

    // One clock: monitor at negedge, FIFO pops and wfm_done drive after posedge
    task automatic step();
        logic [N-1:0] pop_vec;
        exp_t e;
        @(negedge clk);
        checks++;
        if ((bus.hdr_rd & ~bus.hdr_rdy) !== '0 || $countones(bus.hdr_rd) > 1) begin
            failures++;
            $display("FAIL hdr_rd_legal: hdr_rd=%h hdr_rdy=%h", bus.hdr_rd, bus.hdr_rdy);
        end
        pop_vec = bus.hdr_rd;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_accept: chan=%0d, none expected", bus.out_chan);
            end else begin
                e = sb.pop_front();
                if (bus.out_chan !== e.chan || bus.out_bundle !== e.bundle) begin
                    failures++;
                    $display("FAIL accept_order: got chan=%0d bundle=%h, want chan=%0d bundle=%h",
                             bus.out_chan, bus.out_bundle, e.chan, e.bundle);
                end
            end
            if (auto_wfm) wfm_timer = wfm_delay;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (pop_vec[c] && fcnt[c] > 0) begin
                for (int k = 0; k < 3; k++) fmem[c][k] = fmem[c][k+1];
                fmem[c][3] = '0;
                fcnt[c]--;
            end
        end
        if (wfm_timer > 0) begin
            wfm_timer--;
            bus.wfm_done = (wfm_timer == 0);
        end else begin
            bus.wfm_done = 1'b0;
        end
    endtask

    // Run until every expected header is accepted and the arbiter is idle again
    task automatic drain(int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && busy === 1'b0 && wfm_timer == 0 && bus.wfm_done === 1'b0)
               && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!(sb.size() == 0 && busy === 1'b0)) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d busy=%b after %0d cycles, want 0/0",
                     sb.size(), busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_bundle !== '0 || bus.out_chan !== 5'd0) begin
            failures++;
            $display("FAIL reset_out: valid=%b chan=%0d bundle=%h, want 0", bus.out_valid,
                     bus.out_chan, bus.out_bundle);
        end
        checks++;
        if (busy !== 1'b0 || locked !== 1'b0 || err !== 1'b0 || hdr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_status: busy=%b locked=%b err=%b cnt=%0d, want 0",
                     busy, locked, err, hdr_cnt);
        end
        checks++;
        if (bus.hdr_rd !== '0) begin
            failures++;
            $display("FAIL reset_hdr_rd: got %h want 0", bus.hdr_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_fairness();
        for (int rep = 0; rep < 2; rep++)
            for (int c = 0; c < N; c++) push_hdr(c, mk(c, 1'b0), 1'b1);
        drain(2000);
        checks++;
        if (hdr_cnt !== 32'd48) begin
            failures++;
            $display("FAIL fairness_cnt: got %0d want 48", hdr_cnt);
        end
    endtask

    task automatic test_skip_wrap();
        push_hdr(21, mk(21, 1'b0), 1'b1);
        drain(100);
        push_hdr(22, mk(22, 1'b0), 1'b1);
        push_hdr(3, mk(3, 1'b0), 1'b1);
        drain(100);
        // Pointer must now sit at 4: channel 4 wins over channel 2
        push_hdr(4, mk(4, 1'b0), 1'b1);
        push_hdr(2, mk(2, 1'b0), 1'b1);
        drain(100);
    endtask

    task automatic test_partial_lock();
        logic [W-1:0] g1;
        exp_t e;
        g1 = mk(6, 1'b0);
        push_hdr(5, mk(5, 1'b1), 1'b1);
        push_hdr(6, g1, 1'b0);
        drain(100);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_set: locked=%b want 1", locked);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.hdr_rd !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL lock_hold: hdr_rd=%h busy=%b want 0/0", bus.hdr_rd, busy);
            end
        end
        push_hdr(5, mk(5, 1'b0), 1'b1);
        e.chan = 5'd6;
        e.bundle = g1;
        sb.push_back(e);
        drain(100);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_clear: locked=%b want 0", locked);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] b9;
        logic [31:0]  cnt0;
        b9 = mk(9, 1'b0);
        cnt0 = hdr_cnt;
        bus.out_ready = 1'b0;
        push_hdr(9, b9, 1'b1);
        push_hdr(10, mk(10, 1'b0), 1'b1);
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bundle !== b9 || bus.out_chan !== 5'd9 ||
                bus.hdr_rd !== '0 || hdr_cnt !== cnt0) begin
                failures++;
                $display("FAIL backpressure_hold: valid=%b chan=%0d rd=%h cnt=%0d, want 1/9/0/%0d",
                         bus.out_valid, bus.out_chan, bus.hdr_rd, hdr_cnt, cnt0);
            end
        end
        bus.out_ready = 1'b1;
        drain(100);
        checks++;
        if (hdr_cnt !== cnt0 + 32'd2) begin
            failures++;
            $display("FAIL backpressure_cnt: got %0d want %0d", hdr_cnt, cnt0 + 32'd2);
        end
    endtask

    task automatic test_mismatch();
        push_hdr(7, mk(9, 1'b0), 1'b1);
        step();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_set: err=%b want 1", err);
        end
        drain(100);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_clr: err=%b want 0", err);
        end
        err_clr = 1'b1;
        push_hdr(8, mk(1, 1'b0), 1'b1);
        step();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_set_wins: err=%b want 1", err);
        end
        drain(100);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_clr2: err=%b want 0", err);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] b2, b15;
        exp_t e;
        int n;
        push_hdr(12, mk(12, 1'b1), 1'b1);
        drain(100);
        auto_wfm = 1'b0;
        push_hdr(12, mk(12, 1'b1), 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        checks++;
        if (busy !== 1'b1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL midop_pre: busy=%b locked=%b want 1/1", busy, locked);
        end
        b2 = mk(2, 1'b0);
        b15 = mk(15, 1'b0);
        push_hdr(2, b2, 1'b0);
        push_hdr(15, b15, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || locked !== 1'b0 || bus.out_valid !== 1'b0 || bus.hdr_rd !== '0 ||
            bus.out_bundle !== '0 || bus.out_chan !== 5'd0 || hdr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL midop_reset: busy=%b locked=%b valid=%b rd=%h chan=%0d cnt=%0d, want 0",
                     busy, locked, bus.out_valid, bus.hdr_rd, bus.out_chan, hdr_cnt);
        end
        repeat (3) step();
        rst = 1'b0;
        auto_wfm = 1'b1;
        e.chan = 5'd2;
        e.bundle = b2;
        sb.push_back(e);
        e.chan = 5'd15;
        e.bundle = b15;
        sb.push_back(e);
        drain(100);
        checks++;
        if (hdr_cnt !== 32'd2) begin
            failures++;
            $display("FAIL midop_cnt: got %0d want 2", hdr_cnt);
        end
    endtask

    task automatic test_enable();
        logic [W-1:0] b21;
        exp_t e;
        b21 = mk(21, 1'b0);
        push_hdr(20, mk(20, 1'b0), 1'b1);
        push_hdr(21, b21, 1'b0);
        step();
        en = 1'b0;
        drain(100);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.hdr_rd !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL enable_off: hdr_rd=%h busy=%b want 0/0", bus.hdr_rd, busy);
            end
        end
        en = 1'b1;
        e.chan = 5'd21;
        e.bundle = b21;
        sb.push_back(e);
        drain(100);
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            fcnt[c] = 0;
            for (int k = 0; k < 4; k++) fmem[c][k] = '0;
        end
        rst = 1'b1;
        en = 1'b1;
        err_clr = 1'b0;
        bus.out_ready = 1'b1;
        bus.wfm_done = 1'b0;
        test_reset();
        test_fairness();
        test_skip_wrap();
        test_partial_lock();
        test_backpressure();
        test_mismatch();
        test_reset_midop();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
